// File: rtl/i2c_gain_target_pkg.sv
// Shared definitions for the I2C front-end of the PID gain register file.
package i2c_gain_target_pkg;

    localparam int K_P_ADDR      = 0;
    localparam int K_I_ADDR      = K_P_ADDR + 1;
    localparam int K_D_ADDR      = K_I_ADDR + 1;
    localparam int NUM_GAIN_REGS = K_D_ADDR + 1;
    localparam int GAIN_W        = 6;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into the clk domain and derives edge pulses and
// START/STOP conditions.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // [0],[1] form the synchronizer, [2] is history for edge detection
    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic       sda_rise;
    logic       sda_fall;

    // Reset to the idle-bus level so leaving reset never fakes an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_in};
            sda_q <= {sda_q[1:0], sda_in};
        end
    end

    assign sda      = sda_q[1];
    assign scl_rise =  scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] &  scl_q[2];
    assign sda_rise =  sda_q[1] & ~sda_q[2];
    assign sda_fall = ~sda_q[1] &  sda_q[2];
    assign start    = sda_fall & scl_q[1];
    assign stop     = sda_rise & scl_q[1];

endmodule

// File: rtl/i2c_gain_target.sv
// I2C target that turns byte transfers into write strobes and read requests
// on the gain register file, with an auto-incrementing register pointer.
module i2c_gain_target
    import i2c_gain_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h2A,
    parameter int         NUM_REGS = NUM_GAIN_REGS,
    parameter int         DATA_W   = GAIN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [7:0]        reg_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] ptr;
    logic       rw;
    logic       ack_ok;
    logic       slot;
    logic       rd_pend;
    logic [7:0] rx_byte;
    logic       in_range;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    function automatic logic [7:0] next_ptr(input logic [7:0] p);
        return (p == 8'(NUM_REGS - 1)) ? 8'd0 : p + 8'd1;
    endfunction

    assign rx_byte  = {shift[6:0], sda};
    assign in_range = (ptr < 8'(NUM_REGS));
    assign reg_addr = ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            ptr     <= 8'd0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            wr_data <= '0;
            rw      <= 1'b0;
            ack_ok  <= 1'b0;
            slot    <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            rd_pend <= rd_en;
            // Register file answers one clk after rd_en
            if (rd_pend)
                shift <= 8'(rd_data);

            if (start) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
            end else if (stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_cnt == 3'd7) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state  <= ADDR_ACK;
                                    rw     <= rx_byte[0];
                                    busy   <= 1'b1;
                                    ack_ok <= 1'b1;
                                    slot   <= 1'b0;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    PTR: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_cnt == 3'd7) begin
                                ptr    <= rx_byte;
                                state  <= PTR_ACK;
                                ack_ok <= 1'b1;
                                slot   <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    WDATA: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_cnt == 3'd7) begin
                                if (in_range) begin
                                    wr_en   <= 1'b1;
                                    wr_data <= rx_byte[DATA_W-1:0];
                                end
                                ack_ok <= in_range;
                                state  <= WDATA_ACK;
                                slot   <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    // First fall opens the ACK slot, second fall closes it
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!slot) begin
                                sda_oe <= ack_ok;
                                slot   <= 1'b1;
                                if (state == WDATA_ACK && ack_ok)
                                    ptr <= next_ptr(ptr);
                            end else begin
                                bit_cnt <= 3'd0;
                                if (state == ADDR_ACK && rw) begin
                                    sda_oe <= ~shift[7];
                                    state  <= RDATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= (state == ADDR_ACK) ? PTR : WDATA;
                                end
                            end
                        end else if (scl_rise && slot && state == ADDR_ACK && rw) begin
                            if (in_range)
                                rd_en <= 1'b1;
                            else
                                shift <= 8'h00;
                        end
                    end

                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                ptr    <= next_ptr(ptr);
                                state  <= RDATA_ACK;
                            end else begin
                                sda_oe  <= ~shift[6];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda) begin
                                if (in_range)
                                    rd_en <= 1'b1;
                                else
                                    shift <= 8'h00;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end else if (scl_fall) begin
                            sda_oe  <= ~shift[7];
                            bit_cnt <= 3'd0;
                            state   <= RDATA;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_gain_target.sv
// Directed bench: bit-banged I2C master, registered register-file model and
// strobe monitor around i2c_gain_target.
module tb_i2c_gain_target;

    localparam int Q = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [5:0] wr_data;
    logic       wr_en;
    logic       rd_en;
    logic [5:0] rd_data = 6'd0;
    logic       busy;
    logic       sda_line;

    logic [5:0] rf [0:3];

    int checks = 0;
    int failures = 0;

    int wr_cnt = 0;
    int rd_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    logic       wr_en_prev = 1'b0;
    logic [7:0] wr_addr_log [0:63];
    logic [5:0] wr_data_log [0:63];
    logic [7:0] rd_addr_log [0:63];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_gain_target dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (rd_en)
            rd_data <= (reg_addr < 8'd3) ? rf[reg_addr[1:0]] : 6'd0;
    end

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 64) begin
                wr_addr_log[wr_cnt] <= reg_addr;
                wr_data_log[wr_cnt] <= wr_data;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (rd_en) begin
            if (rd_cnt < 64)
                rd_addr_log[rd_cnt] <= reg_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (sda_oe)
            oe_cnt <= oe_cnt + 1;
        if (busy)
            busy_cnt <= busy_cnt + 1;
        if (wr_en && rd_en)
            both_cnt <= both_cnt + 1;
        if (wr_en && wr_en_prev)
            wide_cnt <= wide_cnt + 1;
        wr_en_prev <= wr_en;
    end

    task automatic i2c_bit(input logic b, output logic r);
        sda_m = b;
        #Q scl_m = 1'b1;
        #Q r = sda_line;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--)
            i2c_bit(b[i], r);
        i2c_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic master_ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            b[i] = r;
        end
        i2c_bit(master_ack, r);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({sda_oe, wr_en, rd_en, busy, reg_addr, wr_data} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {sda_oe, wr_en, rd_en, busy, reg_addr, wr_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        logic [2:0] acks;
        int base;
        base = wr_cnt;
        i2c_start();
        wr_byte(8'h54, acks[2]);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL write_busy_high: got %b expected 1", busy);
        end
        wr_byte(8'h01, acks[1]);
        wr_byte(8'h25, acks[0]);
        i2c_stop();
        checks++;
        if (acks !== 3'b000) begin
            failures++;
            $display("FAIL write_acks: got %b expected 000", acks);
        end
        checks++;
        if (wr_cnt - base !== 1) begin
            failures++;
            $display("FAIL write_strobe_count: got %0d expected 1", wr_cnt - base);
        end else begin
            checks++;
            if (wr_addr_log[base] !== 8'd1 || wr_data_log[base] !== 6'h25) begin
                failures++;
                $display("FAIL write_addr_data: got addr %0d data %h expected addr 1 data 25",
                         wr_addr_log[base], wr_data_log[base]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL write_busy_after_stop: got %b expected 0", busy);
        end
        checks++;
        if (reg_addr !== 8'd2) begin
            failures++;
            $display("FAIL write_ptr_incr: got %0d expected 2", reg_addr);
        end
    endtask

    task automatic test_burst_wrap();
        logic [3:0] acks;
        int base;
        base = wr_cnt;
        i2c_start();
        wr_byte(8'h54, acks[3]);
        wr_byte(8'h02, acks[2]);
        wr_byte(8'h11, acks[1]);
        wr_byte(8'h22, acks[0]);
        i2c_stop();
        checks++;
        if (acks !== 4'b0000) begin
            failures++;
            $display("FAIL burst_acks: got %b expected 0000", acks);
        end
        checks++;
        if (wr_cnt - base !== 2) begin
            failures++;
            $display("FAIL burst_strobe_count: got %0d expected 2", wr_cnt - base);
        end else begin
            checks++;
            if (wr_addr_log[base] !== 8'd2 || wr_data_log[base] !== 6'h11) begin
                failures++;
                $display("FAIL burst_first: got addr %0d data %h expected addr 2 data 11",
                         wr_addr_log[base], wr_data_log[base]);
            end
            checks++;
            if (wr_addr_log[base+1] !== 8'd0 || wr_data_log[base+1] !== 6'h22) begin
                failures++;
                $display("FAIL burst_wrap: got addr %0d data %h expected addr 0 data 22",
                         wr_addr_log[base+1], wr_data_log[base+1]);
            end
        end
        checks++;
        if (reg_addr !== 8'd1) begin
            failures++;
            $display("FAIL burst_ptr_end: got %0d expected 1", reg_addr);
        end
    endtask

    task automatic test_read();
        logic [2:0] acks;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int rbase;
        int wbase;
        int oe0;
        rf[0] = 6'h3F;
        rf[1] = 6'h05;
        rf[2] = 6'h00;
        rf[3] = 6'h00;
        rbase = rd_cnt;
        wbase = wr_cnt;
        i2c_start();
        wr_byte(8'h54, acks[2]);
        wr_byte(8'h00, acks[1]);
        i2c_start();
        wr_byte(8'h55, acks[0]);
        checks++;
        if (acks !== 3'b000) begin
            failures++;
            $display("FAIL read_setup_acks: got %b expected 000", acks);
        end
        rd_byte(1'b0, b0);
        rd_byte(1'b1, b1);
        checks++;
        if (b0 !== 8'h3F) begin
            failures++;
            $display("FAIL read_byte0: got %h expected 3f", b0);
        end
        checks++;
        if (b1 !== 8'h05) begin
            failures++;
            $display("FAIL read_byte1: got %h expected 05", b1);
        end
        checks++;
        if (rd_cnt - rbase !== 2) begin
            failures++;
            $display("FAIL read_rd_en_count: got %0d expected 2", rd_cnt - rbase);
        end else begin
            checks++;
            if (rd_addr_log[rbase] !== 8'd0 || rd_addr_log[rbase+1] !== 8'd1) begin
                failures++;
                $display("FAIL read_rd_addrs: got %0d,%0d expected 0,1",
                         rd_addr_log[rbase], rd_addr_log[rbase+1]);
            end
        end
        // Extra clocked byte after NACK must find the target silent
        oe0 = oe_cnt;
        rd_byte(1'b1, b2);
        checks++;
        if (b2 !== 8'hFF || oe_cnt !== oe0 || rd_cnt - rbase !== 2) begin
            failures++;
            $display("FAIL read_wait_stop: got byte %h oe_cycles %0d rd_en %0d expected ff 0 2",
                     b2, oe_cnt - oe0, rd_cnt - rbase);
        end
        i2c_stop();
        checks++;
        if (reg_addr !== 8'd2 || wr_cnt !== wbase) begin
            failures++;
            $display("FAIL read_ptr_end: got ptr %0d writes %0d expected ptr 2 writes 0",
                     reg_addr, wr_cnt - wbase);
        end
    endtask

    task automatic test_mismatch();
        logic [2:0] acks;
        int wbase;
        int rbase;
        int oe0;
        int busy0;
        wbase = wr_cnt;
        rbase = rd_cnt;
        oe0   = oe_cnt;
        busy0 = busy_cnt;
        i2c_start();
        wr_byte(8'h56, acks[2]);
        wr_byte(8'h01, acks[1]);
        wr_byte(8'h25, acks[0]);
        i2c_stop();
        checks++;
        if (acks !== 3'b111) begin
            failures++;
            $display("FAIL mismatch_nacks: got %b expected 111", acks);
        end
        checks++;
        if (oe_cnt !== oe0 || busy_cnt !== busy0) begin
            failures++;
            $display("FAIL mismatch_quiet: got oe_cycles %0d busy_cycles %0d expected 0 0",
                     oe_cnt - oe0, busy_cnt - busy0);
        end
        checks++;
        if (wr_cnt !== wbase || rd_cnt !== rbase) begin
            failures++;
            $display("FAIL mismatch_strobes: got wr %0d rd %0d expected 0 0",
                     wr_cnt - wbase, rd_cnt - rbase);
        end
        i2c_start();
        wr_byte(8'h54, acks[2]);
        wr_byte(8'h00, acks[1]);
        wr_byte(8'h07, acks[0]);
        i2c_stop();
        checks++;
        if (acks !== 3'b000 || wr_cnt - wbase !== 1) begin
            failures++;
            $display("FAIL mismatch_recover: got acks %b writes %0d expected 000 1",
                     acks, wr_cnt - wbase);
        end else begin
            checks++;
            if (wr_addr_log[wbase] !== 8'd0 || wr_data_log[wbase] !== 6'h07) begin
                failures++;
                $display("FAIL mismatch_recover_data: got addr %0d data %h expected 0 07",
                         wr_addr_log[wbase], wr_data_log[wbase]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] acks;
        int wbase;
        wbase = wr_cnt;
        i2c_start();
        wr_byte(8'h54, acks[2]);
        wr_byte(8'h07, acks[1]);
        wr_byte(8'h12, acks[0]);
        i2c_stop();
        checks++;
        if (acks !== 3'b001) begin
            failures++;
            $display("FAIL oor_acks: got %b expected 001", acks);
        end
        checks++;
        if (wr_cnt !== wbase || reg_addr !== 8'd7) begin
            failures++;
            $display("FAIL oor_no_write: got writes %0d ptr %0d expected 0 7",
                     wr_cnt - wbase, reg_addr);
        end
    endtask

    task automatic test_reset_midtransfer();
        logic [1:0] acks;
        logic [7:0] d;
        logic r;
        int wbase;
        d = 8'h0A;
        i2c_start();
        wr_byte(8'h54, acks[1]);
        wr_byte(8'h02, acks[0]);
        for (int i = 7; i >= 0; i--)
            i2c_bit(d[i], r);
        // Open the ACK slot and reset while the target holds SDA low
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q;
        checks++;
        if (sda_oe !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_ack_driven: got %b expected 1", sda_oe);
        end
        @(negedge clk);
        rst_n = 1'b0;
        wbase = wr_cnt;
        @(posedge clk);
        #1;
        checks++;
        if (sda_oe !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_release: got sda_oe %b busy %b expected 0 0", sda_oe, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #Q scl_m = 1'b0;
        #Q;
        checks++;
        if (wr_cnt !== wbase || sda_oe !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_no_strobe: got writes %0d sda_oe %b expected 0 0",
                     wr_cnt - wbase, sda_oe);
        end
        i2c_start();
        wr_byte(8'h54, acks[1]);
        wr_byte(8'h01, acks[0]);
        wr_byte(8'h15, r);
        i2c_stop();
        checks++;
        if ({acks, r} !== 3'b000 || wr_cnt - wbase !== 1) begin
            failures++;
            $display("FAIL rst_mid_recover: got acks %b writes %0d expected 000 1",
                     {acks, r}, wr_cnt - wbase);
        end else begin
            checks++;
            if (wr_addr_log[wbase] !== 8'd1 || wr_data_log[wbase] !== 6'h15) begin
                failures++;
                $display("FAIL rst_mid_recover_data: got addr %0d data %h expected 1 15",
                         wr_addr_log[wbase], wr_data_log[wbase]);
            end
        end
    endtask

    task automatic test_strobe_hygiene();
        checks++;
        if (both_cnt !== 0 || wide_cnt !== 0) begin
            failures++;
            $display("FAIL strobe_hygiene: got overlap %0d wide %0d expected 0 0",
                     both_cnt, wide_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_burst_wrap();
        test_read();
        test_mismatch();
        test_out_of_range();
        test_reset_midtransfer();
        test_strobe_hygiene();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
